// File: rtl/calc2_core.sv
// calc2_core: multi-channel calculator core. Each of NUM_CH channels takes a
// two-beat request (command + op1, then op2). A round-robin arbiter feeds one
// request per cycle into a single registered ALU. The result comes back on the
// requesting channel for exactly one cycle.
//
// Ports:
//   c_clk        clock, rising edge
//   reset        synchronous, active-low
//   req_cmd_in   NUM_CH x 4-bit command, channel i at [4i+3:4i]
//   req_data_in  NUM_CH x DATA_W operand, channel i at slice i
//   req_busy     per channel: accepted request not yet answered
//   out_resp     NUM_CH x 2-bit code: 00 none, 01 ok, 10 over/underflow, 11 invalid
//   out_data     NUM_CH x DATA_W result, nonzero only alongside out_resp
//
// Build option: define CALC2_CMP_EN to enable command 4'hC (unsigned compare).
module calc2_core #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32
) (
  input  logic                     c_clk,
  input  logic                     reset,
  input  logic [NUM_CH*4-1:0]      req_cmd_in,
  input  logic [NUM_CH*DATA_W-1:0] req_data_in,
  output logic [NUM_CH-1:0]        req_busy,
  output logic [NUM_CH*2-1:0]      out_resp,
  output logic [NUM_CH*DATA_W-1:0] out_data
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int SH_W = $clog2(DATA_W);

  localparam logic [3:0] CMD_ADD = 4'h1;
  localparam logic [3:0] CMD_SUB = 4'h2;
  localparam logic [3:0] CMD_SHL = 4'h5;
  localparam logic [3:0] CMD_SHR = 4'h6;
  localparam logic [3:0] CMD_CMP = 4'hC;

  localparam logic [1:0] RSP_OK  = 2'b01;
  localparam logic [1:0] RSP_OVF = 2'b10;
  localparam logic [1:0] RSP_INV = 2'b11;

  // ST_GNT marks a channel whose request is inside the ALU stage.
  typedef enum logic [1:0] {ST_IDLE, ST_OP2, ST_PEND, ST_GNT} ch_state_e;

  ch_state_e         state_q [NUM_CH];
  ch_state_e         state_d [NUM_CH];
  logic [3:0]        cmd_q   [NUM_CH];
  logic [3:0]        cmd_d   [NUM_CH];
  logic [DATA_W-1:0] op1_q   [NUM_CH];
  logic [DATA_W-1:0] op1_d   [NUM_CH];
  logic [DATA_W-1:0] op2_q   [NUM_CH];
  logic [DATA_W-1:0] op2_d   [NUM_CH];

  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic              gnt_vld;
  logic [CH_W-1:0]   gnt_idx;

  logic              vld_p0_q, vld_p0_d;
  logic [CH_W-1:0]   ch_p0_q, ch_p0_d;
  logic [3:0]        cmd_p0_q, cmd_p0_d;
  logic [DATA_W-1:0] op1_p0_q, op1_p0_d;
  logic [DATA_W-1:0] op2_p0_q, op2_p0_d;

  logic [DATA_W+1:0]        alu_res;
  logic [NUM_CH*2-1:0]      out_resp_q, out_resp_d;
  logic [NUM_CH*DATA_W-1:0] out_data_q, out_data_d;

  // Returns {resp, data}. Overflow, underflow and invalid commands all clamp
  // the data to zero.
  function automatic logic [DATA_W+1:0] alu_f(input logic [3:0]        cmd,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic [DATA_W:0]   sum;
    logic [SH_W-1:0]   sh;
    sum   = {1'b0, a} + {1'b0, b};
    sh    = b[SH_W-1:0];
    alu_f = {RSP_INV, {DATA_W{1'b0}}};
    case (cmd)
      CMD_ADD: alu_f = sum[DATA_W] ? {RSP_OVF, {DATA_W{1'b0}}} : {RSP_OK, sum[DATA_W-1:0]};
      CMD_SUB: alu_f = (a < b) ? {RSP_OVF, {DATA_W{1'b0}}} : {RSP_OK, a - b};
      CMD_SHL: alu_f = {RSP_OK, a << sh};
      CMD_SHR: alu_f = {RSP_OK, a >> sh};
`ifdef CALC2_CMP_EN
      CMD_CMP: alu_f = {RSP_OK, (a > b) ? DATA_W'(2) : ((a < b) ? DATA_W'(1) : DATA_W'(0))};
`endif
      default: ;
    endcase
  endfunction

  // Round-robin search starting at ptr_q.
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int j = 0; j < NUM_CH; j++) begin
      idx = (int'(ptr_q) + j) % NUM_CH;
      if (!gnt_vld && state_q[idx] == ST_PEND) begin
        gnt_vld = 1'b1;
        gnt_idx = CH_W'(idx);
      end
    end
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
  end

  // Per-channel capture FSMs. Commands arriving while busy are dropped.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cmd_d[i]   = cmd_q[i];
      op1_d[i]   = op1_q[i];
      op2_d[i]   = op2_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (req_cmd_in[4*i +: 4] != 4'h0) begin
            cmd_d[i]   = req_cmd_in[4*i +: 4];
            op1_d[i]   = req_data_in[DATA_W*i +: DATA_W];
            state_d[i] = ST_OP2;
          end
        end
        ST_OP2: begin
          op2_d[i]   = req_data_in[DATA_W*i +: DATA_W];
          state_d[i] = ST_PEND;
        end
        ST_PEND: if (gnt_vld && int'(gnt_idx) == i) state_d[i] = ST_GNT;
        ST_GNT:  state_d[i] = ST_IDLE;
        default: state_d[i] = ST_IDLE;
      endcase
      req_busy[i] = (state_q[i] != ST_IDLE);
    end
  end

  // Stage p0: granted request latched into the ALU input registers.
  always_comb begin
    vld_p0_d = gnt_vld;
    ch_p0_d  = gnt_idx;
    cmd_p0_d = cmd_q[gnt_idx];
    op1_p0_d = op1_q[gnt_idx];
    op2_p0_d = op2_q[gnt_idx];
  end

  // Stage p1: ALU result steered to the owning channel's output slice.
  always_comb begin
    alu_res    = alu_f(cmd_p0_q, op1_p0_q, op2_p0_q);
    out_resp_d = '0;
    out_data_d = '0;
    if (vld_p0_q) begin
      out_resp_d[2*int'(ch_p0_q) +: 2]           = alu_res[DATA_W +: 2];
      out_data_d[DATA_W*int'(ch_p0_q) +: DATA_W] = alu_res[DATA_W-1:0];
    end
  end

  always_ff @(posedge c_clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) state_q[i] <= ST_IDLE;
      ptr_q      <= '0;
      vld_p0_q   <= 1'b0;
      out_resp_q <= '0;
      out_data_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) state_q[i] <= state_d[i];
      ptr_q      <= ptr_d;
      vld_p0_q   <= vld_p0_d;
      out_resp_q <= out_resp_d;
      out_data_q <= out_data_d;
    end
  end

  // Operand and command storage is qualified by the FSM/valid state, so it
  // needs no reset.
  always_ff @(posedge c_clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      cmd_q[i] <= cmd_d[i];
      op1_q[i] <= op1_d[i];
      op2_q[i] <= op2_d[i];
    end
    ch_p0_q  <= ch_p0_d;
    cmd_p0_q <= cmd_p0_d;
    op1_p0_q <= op1_p0_d;
    op2_p0_q <= op2_p0_d;
  end

  assign out_resp = out_resp_q;
  assign out_data = out_data_q;

endmodule

// File: tb/tb_calc2_core.sv
// Testbench for calc2_core: directed scenarios plus randomized multi-channel
// traffic, checked against an arithmetic reference model and a round-robin
// grant-order model.
module tb_calc2_core;
  localparam int NC = 4;
  localparam int DW = 32;
  localparam int VW = NC * DW;

  logic            c_clk = 1'b0;
  logic            reset;
  logic [NC*4-1:0] req_cmd_in;
  logic [VW-1:0]   req_data_in;
  logic [NC-1:0]   req_busy;
  logic [NC*2-1:0] out_resp;
  logic [VW-1:0]   out_data;

  int tests = 0;
  int fails = 0;
  int ptr_model = 0;

  always #5 c_clk = ~c_clk;

  calc2_core #(.NUM_CH(NC), .DATA_W(DW)) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .req_busy    (req_busy),
    .out_resp    (out_resp),
    .out_data    (out_data)
  );

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge c_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // ch < 0 means no channel may respond this cycle.
  task automatic check_outs(input string tag, input logic [NC-1:0] busy, input int ch,
                            input logic [1:0] resp, input logic [DW-1:0] data);
    logic [NC*2-1:0] er;
    logic [VW-1:0]   ed;
    er = '0;
    ed = '0;
    if (ch >= 0) begin
      er[2*ch +: 2]   = resp;
      ed[DW*ch +: DW] = data;
    end
    chk({tag, ".resp"}, VW'(out_resp), VW'(er));
    chk({tag, ".data"}, out_data, ed);
    chk({tag, ".busy"}, VW'(req_busy), VW'(busy));
  endtask

  // Reference ALU computed with wide plain arithmetic.
  function automatic void ref_alu(input logic [3:0] cmd, input logic [DW-1:0] a,
                                  input logic [DW-1:0] b, output logic [1:0] resp,
                                  output logic [DW-1:0] data);
    logic [63:0] s;
    resp = 2'b11;
    data = '0;
    s    = 64'(a) + 64'(b);
    case (cmd)
      4'd1: if (s >= 64'h1_0000_0000) resp = 2'b10;
            else begin resp = 2'b01; data = DW'(s); end
      4'd2: if (a < b) resp = 2'b10;
            else begin resp = 2'b01; data = a - b; end
      4'd5: begin resp = 2'b01; data = a << (b % DW); end
      4'd6: begin resp = 2'b01; data = a >> (b % DW); end
`ifdef CALC2_CMP_EN
      4'd12: begin resp = 2'b01; data = (a > b) ? 2 : ((a < b) ? 1 : 0); end
`endif
      default: ;
    endcase
  endfunction

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick;
      check_outs(tag, '0, -1, 2'b00, '0);
    end
  endtask

  // Issue requests on all channels in mask at the same edge k, then expect
  // one response per cycle from k+3 in round-robin order from ptr_model.
  task automatic run_group(input string tag, input logic [NC-1:0] mask,
                           input logic [NC-1:0][3:0] cmd,
                           input logic [NC-1:0][DW-1:0] a,
                           input logic [NC-1:0][DW-1:0] b, input bit drop_at_k3);
    int            order[$];
    logic [NC-1:0] left;
    logic [1:0]    er;
    logic [DW-1:0] ed;
    int            c;
    for (int i = 0; i < NC; i++) begin
      req_cmd_in[4*i +: 4]   = mask[i] ? cmd[i] : 4'h0;
      req_data_in[DW*i +: DW] = a[i];
    end
    tick;  // edge k
    check_outs({tag, "@k"}, mask, -1, 2'b00, '0);
    for (int i = 0; i < NC; i++) begin
      req_cmd_in[4*i +: 4]   = mask[i] ? 4'($urandom_range(1, 15)) : 4'h0;
      req_data_in[DW*i +: DW] = b[i];
    end
    tick;  // edge k+1: op2 beat, command ignored
    check_outs({tag, "@k+1"}, mask, -1, 2'b00, '0);
    for (int i = 0; i < NC; i++) begin
      req_cmd_in[4*i +: 4]   = mask[i] ? 4'($urandom_range(1, 15)) : 4'h0;
      req_data_in[DW*i +: DW] = DW'($urandom);
    end
    tick;  // edge k+2: busy channels drop this command
    check_outs({tag, "@k+2"}, mask, -1, 2'b00, '0);
    req_cmd_in = '0;
    for (int j = 0; j < NC; j++) begin
      c = (ptr_model + j) % NC;
      if (mask[c]) order.push_back(c);
    end
    left = mask;
    foreach (order[j]) begin
      if (drop_at_k3 && j == 0)
        for (int i = 0; i < NC; i++) if (mask[i]) req_cmd_in[4*i +: 4] = 4'h1;
      tick;
      req_cmd_in = '0;
      left[order[j]] = 1'b0;
      ref_alu(cmd[order[j]], a[order[j]], b[order[j]], er, ed);
      check_outs({tag, "@resp"}, left, order[j], er, ed);
    end
    ptr_model = (order[order.size()-1] + 1) % NC;
  endtask

  function automatic logic [DW-1:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return DW'($urandom_range(0, 40));
      default: return DW'($urandom);
    endcase
  endfunction

  initial begin
    logic [NC-1:0][3:0]    cm;
    logic [NC-1:0][DW-1:0] va;
    logic [NC-1:0][DW-1:0] vb;
    logic [NC-1:0]         mk;

    reset       = 1'b0;
    req_cmd_in  = '0;
    req_data_in = '0;
    tick;
    tick;
    check_outs("reset", '0, -1, 2'b00, '0);
    reset = 1'b1;

    // Uncontended add on channel 0.
    cm = '0; va = '0; vb = '0;
    cm[0] = 4'd1; va[0] = 32'h64; vb[0] = 32'h27;
    run_group("add_ch0", 4'b0001, cm, va, vb, 1'b0);

    // Boundary cases on channel 2.
    cm = '0; va = '0; vb = '0;
    cm[2] = 4'd1; va[2] = 32'hFFFF_FFFF; vb[2] = 32'h1;
    run_group("add_ovf_ch2", 4'b0100, cm, va, vb, 1'b0);
    cm[2] = 4'd2; va[2] = 32'h22; vb[2] = 32'h23;
    run_group("sub_unf_ch2", 4'b0100, cm, va, vb, 1'b0);
    cm[2] = 4'd5; va[2] = 32'h3; vb[2] = 32'h22;
    run_group("shl_ch2", 4'b0100, cm, va, vb, 1'b0);

    // Four-way contention from a fresh arbiter pointer.
    reset = 1'b0;
    tick;
    reset = 1'b1;
    ptr_model = 0;
    check_outs("reset2", '0, -1, 2'b00, '0);
    for (int i = 0; i < NC; i++) begin
      cm[i] = 4'd1; va[i] = 32'd5; vb[i] = 32'd1;
    end
    run_group("contend4", 4'b1111, cm, va, vb, 1'b0);

    // Back-to-back on channel 1: command at k+3 dropped, k+4 accepted.
    cm = '0; va = '0; vb = '0;
    cm[1] = 4'd6; va[1] = 32'hC; vb[1] = 32'd2;
    run_group("shr_drop_ch1", 4'b0010, cm, va, vb, 1'b1);
    cm[1] = 4'd1; va[1] = 32'd1; vb[1] = 32'd1;
    run_group("resend_ch1", 4'b0010, cm, va, vb, 1'b0);
    idle("after_resend", 3);

    // Invalid command and compare on channel 3.
    cm = '0; va = '0; vb = '0;
    cm[3] = 4'h7; va[3] = 32'd10; vb[3] = 32'd3;
    run_group("inv_ch3", 4'b1000, cm, va, vb, 1'b0);
    cm[3] = 4'hC; va[3] = 32'd5; vb[3] = 32'd9;
    run_group("cmp_ch3", 4'b1000, cm, va, vb, 1'b0);

    // Reset at edge k+2 discards the in-flight request.
    req_cmd_in[3:0]   = 4'd1;
    req_data_in[31:0] = 32'h10;
    tick;
    req_cmd_in = '0;
    req_data_in[31:0] = 32'h20;
    tick;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    ptr_model = 0;
    check_outs("mid_reset", '0, -1, 2'b00, '0);
    idle("post_reset", 5);
    cm = '0; va = '0; vb = '0;
    cm[0] = 4'd1; va[0] = 32'h64; vb[0] = 32'h27;
    run_group("add_ch0_again", 4'b0001, cm, va, vb, 1'b0);

    // Randomized traffic over random channel subsets.
    for (int it = 0; it < 60; it++) begin
      mk = NC'($urandom_range(1, (1 << NC) - 1));
      for (int i = 0; i < NC; i++) begin
        case ($urandom_range(0, 7))
          0:       cm[i] = 4'd1;
          1:       cm[i] = 4'd2;
          2:       cm[i] = 4'd5;
          3:       cm[i] = 4'd6;
          4:       cm[i] = 4'hC;
          default: cm[i] = 4'($urandom_range(1, 15));
        endcase
        va[i] = rnd_op();
        vb[i] = rnd_op();
      end
      run_group("rand", mk, cm, va, vb, 1'b0);
    end
    idle("final", 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/calc2_core.md
# calc2_core

Parametrised multi-channel calculator core, successor to the fixed four-channel calc1 design. It accepts two-beat requests (command plus operand 1, then operand 2) on NUM_CH independent ports and shares one registered ALU between them through a round-robin arbiter. It returns a one-cycle response code and result per channel, and adds a per-channel busy indication that calc1 lacked. It sits directly under the calculator top level, in place of calc1_top.

## Interface
- NUM_CH, default 4: number of request/response channels, 2..8.
- DATA_W, default 32: operand and result width, 8..64, power of two.
- c_clk in 1: single clock, rising edge.
- reset in 1: synchronous, active-low; 0 at a rising edge resets the block.
- req_cmd_in in NUM_CH*4: per-channel command; channel i occupies bits [4i+3:4i].
- req_data_in in NUM_CH*DATA_W: per-channel operand; channel i occupies slice i.
- req_busy out NUM_CH: channel holds an accepted request that has not yet responded.
- out_resp out NUM_CH*2: per-channel response code. 00 none, 01 success, 10 overflow/underflow, 11 invalid command.
- out_data out NUM_CH*DATA_W: per-channel result, valid only while that channel's out_resp is nonzero.

## Operation
- Commands: 0 no-op, 1 add, 2 sub (op1 − op2), 5 shift left, 6 shift right. All other values are invalid.
- Per-channel capture FSM, states IDLE → OP2 → PEND → IDLE:
  - IDLE: a nonzero cmd with req_busy=0 is captured together with op1 from req_data_in. The FSM moves to OP2 and req_busy rises.
  - OP2: req_data_in is captured as op2 unconditionally. req_cmd_in is ignored in this beat. The FSM moves to PEND.
  - PEND: the channel requests the arbiter. On grant it stays busy until the response edge, then returns to IDLE.
- Commands presented while req_busy=1 are dropped silently and produce no response.
- Arbiter:
  - Round-robin, one grant per cycle.
  - After a grant to channel i, priority starts at i+1 mod NUM_CH.
  - Out of reset, channel 0 has the highest priority.
- ALU, one registered stage:
  - Add: response 01 with the DATA_W-bit sum. A carry out of bit DATA_W−1 gives response 10 with data 0.
  - Sub: op1 < op2 (unsigned) gives response 10 with data 0. Otherwise response 01 with op1 − op2.
  - Shifts are logical. The shift amount is op2[$clog2(DATA_W)-1:0] and the upper op2 bits are ignored. Bits shifted out are lost. The response is always 01.
  - Invalid command: response 11, data 0. The request still consumes an arbiter slot.
- Response: out_resp and out_data for the granted channel are registered and held for exactly one cycle, then return to 0.

## Timing
- Reset values: all out_resp = 0, out_data = 0, req_busy = 0. All FSMs go to IDLE and the arbiter pointer to channel 0.
- Reset mid-operation discards every captured, pending and in-ALU request. No response for a discarded request ever appears.
- Uncontended latency, with cmd sampled at edge k:
  - op2 is sampled at edge k+1.
  - Grant happens in the cycle after edge k+2.
  - out_resp and out_data are registered at edge k+3 and visible for cycle k+3 to k+4.
  - req_busy is high from edge k to edge k+3 and low at edge k+3.
- Contended latency: each other channel granted first adds one cycle. The worst case is k+3+(NUM_CH−1).
- Back-to-back on one channel: the earliest next command is sampled at edge k+4. A command at edge k+3 sees req_busy=1 before that edge and is dropped.
- Several channels may respond in the same cycle only if they were granted in the same cycle, which cannot happen. At most one channel's out_resp is nonzero per cycle.

## Configuration
- CALC2_CMP_EN defined:
  - Command 4'hC (unsigned compare) is valid.
  - Response 01, data 2 if op1 > op2, 1 if op1 < op2, 0 if equal.
- CALC2_CMP_EN undefined: 4'hC is invalid and returns response 11 with data 0.

## Test plan
- Reset, then channel 0 add 0x64 + 0x27 → channel 0 out_resp=01, out_data=0x8B at edge k+3; req_busy high for edges k..k+2.
- Channel 2 add 0xFFFFFFFF + 0x1 → resp 10, data 0. Channel 2 sub 0x22 − 0x23 → resp 10, data 0. Channel 2 shift left 0x3 by 0x22 (amount 2) → resp 01, data 0xC.
- All four channels issue cmd 1 (5 + 1) at the same edge → responses on channels 0, 1, 2, 3 at k+3, k+4, k+5, k+6, each with data 6, one per cycle.
- Channel 1 shift right 0xC by 2, then a second command at edge k+3 → first returns 01/0x3; the second is dropped with no response. A command re-sent at edge k+4 is accepted.
- Channel 3 cmd 4'h7 → resp 11, data 0. Channel 3 cmd 4'hC with 5 vs 9 → with CALC2_CMP_EN: 01/data 1; without: 11/data 0.
- Channel 0 add issued, reset asserted at edge k+2 → no response ever; all outputs 0; next request after reset behaves per the first scenario.
